mini_alu_seq: RTL and testbench

//  Parametrised, clocked successor to the combinational 4-bit mini ALU.
//  - Adds subtract, sequential shift-add multiply and multiply-accumulate.
//  - Uses valid/ready handshakes on input and output.
//  - Sits between a stimulus source (bench or controller) and a result consumer.
//  - Multi-cycle multiply keeps area small; the accumulator supports running MAC sums.

---
 rtl/mini_alu_seq_if.sv | 27 ++
 rtl/mini_alu_seq.sv | 130 +++++++++++++
 tb/tb_mini_alu_seq.sv | 250 +++++++++++++++++++++++++
 3 files changed

// File: rtl/mini_alu_seq_if.sv
// Handshake bundle for mini_alu_seq: operand/op request side and
// result/flag response side, each with its own valid/ready pair.
interface mini_alu_seq_if #(
    parameter int WIDTH = 4,
    parameter int RES_W = 20
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_a;
    logic [WIDTH-1:0] in_b;
    logic [1:0]       op;
    logic             acc_clr;
    logic             out_valid;
    logic             out_ready;
    logic [RES_W-1:0] result;
    logic             ovf;

    modport master (
        output in_valid, in_a, in_b, op, acc_clr, out_ready,
        input  in_ready, out_valid, result, ovf
    );

    modport slave (
        input  in_valid, in_a, in_b, op, acc_clr, out_ready,
        output in_ready, out_valid, result, ovf
    );
endinterface

// File: rtl/mini_alu_seq.sv
// Clocked mini ALU: ADD/SUB in one exec cycle, MUL/MAC by
// shift-add over WIDTH cycles, with a guarded MAC accumulator.
module mini_alu_seq #(
    parameter int WIDTH = 4,
    parameter int GUARD = 12
) (
    input logic           clk,
    input logic           rst_n,
    mini_alu_seq_if.slave bus
);
    localparam int RES_W = 2*WIDTH + GUARD;
    localparam int PW    = 2*WIDTH;
    localparam int SW    = RES_W + 1;
    localparam int CW    = $clog2(WIDTH);

    typedef enum logic [1:0] {IDLE, EXEC, MUL, DONE} state_t;

    state_t           state;
    state_t           state_nx;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic             mode;
    logic [PW-1:0]    mcand;
    logic [PW-1:0]    prod;
    logic [PW-1:0]    prod_nx;
    logic [CW-1:0]    cnt;
    logic [RES_W-1:0] result_q;
    logic [RES_W-1:0] acc;
    logic [RES_W-1:0] acc_base;
    logic [RES_W-1:0] ex_res;
    logic [SW-1:0]    mac_sum;
    logic [WIDTH:0]   sum_ab;
    logic [WIDTH:0]   dif_ab;
    logic             ovf_q;
    logic             out_valid_q;
    logic             accept;
    logic             last_step;
    logic             hs;

    assign accept    = bus.in_valid && (state == IDLE);
    assign last_step = (state == MUL) && (cnt == CW'(WIDTH-1));
    assign hs        = out_valid_q && bus.out_ready;

    assign prod_nx  = b_q[0] ? prod + mcand : prod;
    // A clear in the final MAC cycle wins over the old accumulator.
    assign acc_base = bus.acc_clr ? '0 : acc;
    assign mac_sum  = {1'b0, acc_base} + SW'(prod_nx);

    assign sum_ab = {1'b0, a_q} + {1'b0, b_q};
    assign dif_ab = {1'b0, a_q} - {1'b0, b_q};

    always_comb begin
        ex_res = RES_W'(sum_ab);
        unique case (1'b1)
            mode:    ex_res = {{(RES_W-WIDTH-1){dif_ab[WIDTH]}}, dif_ab};
            default: ex_res = RES_W'(sum_ab);
        endcase
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE:    if (accept) state_nx = bus.op[1] ? MUL : EXEC;
            EXEC:    state_nx = DONE;
            MUL:     if (last_step) state_nx = DONE;
            DONE:    if (hs) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_q   <= '0;
            b_q   <= '0;
            mode  <= 1'b0;
            mcand <= '0;
            prod  <= '0;
            cnt   <= '0;
        end else if (accept) begin
            a_q   <= bus.in_a;
            b_q   <= bus.in_b;
            mode  <= bus.op[0];
            mcand <= PW'(bus.in_a);
            prod  <= '0;
            cnt   <= '0;
        end else if (state == MUL) begin
            prod  <= prod_nx;
            mcand <= mcand << 1;
            b_q   <= b_q >> 1;
            cnt   <= cnt + CW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            result_q    <= '0;
            acc         <= '0;
            ovf_q       <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            if (state == EXEC) begin
                result_q <= ex_res;
            end else if (last_step) begin
                result_q <= mode ? mac_sum[RES_W-1:0] : RES_W'(prod_nx);
            end
            if (last_step && mode) begin
                acc   <= mac_sum[RES_W-1:0];
                ovf_q <= (ovf_q && !bus.acc_clr) || mac_sum[RES_W];
            end else if (bus.acc_clr) begin
                acc   <= '0;
                ovf_q <= 1'b0;
            end
            // Valid is registered off DONE, adding one cycle of latency.
            out_valid_q <= (state == DONE) && !hs;
        end
    end

    assign bus.in_ready  = (state == IDLE);
    assign bus.out_valid = out_valid_q;
    assign bus.result    = result_q;
    assign bus.ovf       = ovf_q;
endmodule

// File: tb/tb_mini_alu_seq.sv
// Scoreboard bench for mini_alu_seq: default build plus a GUARD=0
// build to exercise MAC wraparound and the sticky overflow flag.
module tb_mini_alu_seq;
    typedef struct {
        logic [19:0] res;
        logic        ovf;
        int          at;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n;
    int   cyc = 0;
    int   total = 0;
    int   bad = 0;
    exp_t mq[$];
    exp_t gq[$];
    bit   mseen = 0;
    bit   gseen = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    mini_alu_seq_if #(.WIDTH(4), .RES_W(20)) m();
    mini_alu_seq_if #(.WIDTH(4), .RES_W(8))  g();

    mini_alu_seq #(.WIDTH(4), .GUARD(12)) dut (
        .clk(clk), .rst_n(rst_n), .bus(m)
    );
    mini_alu_seq #(.WIDTH(4), .GUARD(0)) dut_g (
        .clk(clk), .rst_n(rst_n), .bus(g)
    );

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (rst_n === 1'b1 && m.out_valid === 1'b1) begin
            if (mq.size() == 0) begin
                total++;
                bad++;
                $display("FAIL m_spurious: got out_valid=1 want 0");
            end else begin
                if (!mseen) begin
                    chk("m_res", 32'(m.result), 32'(mq[0].res));
                    chk("m_ovf", 32'(m.ovf), 32'(mq[0].ovf));
                    chk("m_lat", cyc, mq[0].at);
                    mseen = 1;
                end
                if (m.out_ready) begin
                    chk("m_hold", 32'(m.result), 32'(mq[0].res));
                    void'(mq.pop_front());
                    mseen = 0;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (rst_n === 1'b1 && g.out_valid === 1'b1) begin
            if (gq.size() == 0) begin
                total++;
                bad++;
                $display("FAIL g_spurious: got out_valid=1 want 0");
            end else begin
                if (!gseen) begin
                    chk("g_res", 32'(g.result), 32'(gq[0].res));
                    chk("g_ovf", 32'(g.ovf), 32'(gq[0].ovf));
                    chk("g_lat", cyc, gq[0].at);
                    gseen = 1;
                end
                if (g.out_ready) begin
                    chk("g_hold", 32'(g.result), 32'(gq[0].res));
                    void'(gq.pop_front());
                    gseen = 0;
                end
            end
        end
    end

    // Callers sit 2ns after a rising edge; accept happens on the next one.
    task automatic issue(input logic [3:0] a, input logic [3:0] b,
                         input logic [1:0] o, input logic clr,
                         input logic [19:0] r, input logic v, input int lat);
        int n = 0;
        while (m.in_ready !== 1'b1) begin
            @(posedge clk); #2;
            n++;
            if (n > 50) begin
                total++;
                bad++;
                $display("FAIL m_ready_timeout: got in_ready=0 want 1");
                return;
            end
        end
        m.in_valid = 1'b1;
        m.in_a = a;
        m.in_b = b;
        m.op = o;
        m.acc_clr = clr;
        mq.push_back('{r, v, cyc + 1 + lat});
        @(posedge clk); #2;
        m.in_valid = 1'b0;
        m.acc_clr = 1'b0;
        chk("m_busy", 32'(m.in_ready), 32'd0);
    endtask

    task automatic issue_g(input logic [3:0] a, input logic [3:0] b,
                           input logic [1:0] o, input logic clr,
                           input logic [19:0] r, input logic v, input int lat);
        int n = 0;
        while (g.in_ready !== 1'b1) begin
            @(posedge clk); #2;
            n++;
            if (n > 50) begin
                total++;
                bad++;
                $display("FAIL g_ready_timeout: got in_ready=0 want 1");
                return;
            end
        end
        g.in_valid = 1'b1;
        g.in_a = a;
        g.in_b = b;
        g.op = o;
        g.acc_clr = clr;
        gq.push_back('{r, v, cyc + 1 + lat});
        @(posedge clk); #2;
        g.in_valid = 1'b0;
        g.acc_clr = 1'b0;
        chk("g_busy", 32'(g.in_ready), 32'd0);
    endtask

    task automatic drain();
        int n = 0;
        while (mq.size() != 0 || gq.size() != 0) begin
            @(posedge clk); #2;
            n++;
            if (n > 100) begin
                total++;
                bad++;
                $display("FAIL drain_timeout: got pending=%0d want 0",
                         mq.size() + gq.size());
                mq.delete();
                gq.delete();
                return;
            end
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got no finish want finish");
        $fatal(1);
    end

    initial begin
        int n;
        rst_n = 1'b1;
        m.in_valid = 1'b0; m.in_a = '0; m.in_b = '0;
        m.op = '0; m.acc_clr = 1'b0; m.out_ready = 1'b1;
        g.in_valid = 1'b0; g.in_a = '0; g.in_b = '0;
        g.op = '0; g.acc_clr = 1'b0; g.out_ready = 1'b1;
        #1 rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        chk("rst_in_ready", 32'(m.in_ready), 32'd1);
        chk("rst_out_valid", 32'(m.out_valid), 32'd0);
        chk("rst_result", 32'(m.result), 32'd0);
        chk("rst_ovf", 32'(m.ovf), 32'd0);
        rst_n = 1'b1;
        @(posedge clk); #2;

        issue(4'd15, 4'd15, 2'b00, 1'b0, 20'd30, 1'b0, 2);
        drain();
        issue(4'd3, 4'd5, 2'b01, 1'b0, 20'hFFFFE, 1'b0, 2);
        issue(4'd9, 4'd4, 2'b01, 1'b0, 20'd5, 1'b0, 2);
        drain();

        for (int a = 0; a < 16; a++) begin
            for (int b = 0; b < 16; b++) begin
                issue(4'(a), 4'(b), 2'b10, 1'b0, 20'(a * b), 1'b0, 5);
            end
        end
        drain();

        issue(4'd15, 4'd15, 2'b11, 1'b1, 20'd225, 1'b0, 5);
        issue(4'd15, 4'd15, 2'b11, 1'b0, 20'd450, 1'b0, 5);
        issue(4'd15, 4'd15, 2'b11, 1'b0, 20'd675, 1'b0, 5);
        drain();
        issue(4'd2, 4'd3, 2'b11, 1'b0, 20'd6, 1'b0, 5);
        m.acc_clr = 1'b1;
        @(posedge clk); #2;
        m.acc_clr = 1'b0;
        drain();

        issue_g(4'd15, 4'd15, 2'b11, 1'b1, 20'd225, 1'b0, 5);
        issue_g(4'd15, 4'd15, 2'b11, 1'b0, 20'd194, 1'b1, 5);
        issue_g(4'd2, 4'd3, 2'b10, 1'b0, 20'd6, 1'b1, 5);
        issue_g(4'd1, 4'd1, 2'b11, 1'b1, 20'd1, 1'b0, 5);
        drain();

        m.out_ready = 1'b0;
        issue(4'd7, 4'd9, 2'b10, 1'b0, 20'd63, 1'b0, 5);
        n = 0;
        while (m.out_valid !== 1'b1 && n < 20) begin
            @(posedge clk); #2;
            n++;
        end
        m.in_valid = 1'b1; m.in_a = 4'd1; m.in_b = 4'd1; m.op = 2'b00;
        repeat (10) begin
            @(posedge clk); #2;
            chk("bp_valid", 32'(m.out_valid), 32'd1);
            chk("bp_result", 32'(m.result), 32'd63);
            chk("bp_in_ready", 32'(m.in_ready), 32'd0);
        end
        m.in_valid = 1'b0;
        m.out_ready = 1'b1;
        @(posedge clk); #2;
        chk("bp_release", 32'(m.out_valid), 32'd0);
        chk("bp_popped", mq.size(), 0);

        issue(4'd5, 4'd6, 2'b10, 1'b0, 20'd30, 1'b0, 5);
        @(posedge clk); #2;
        rst_n = 1'b0;
        #1;
        chk("arst_out_valid", 32'(m.out_valid), 32'd0);
        chk("arst_in_ready", 32'(m.in_ready), 32'd1);
        chk("arst_result", 32'(m.result), 32'd0);
        chk("arst_ovf", 32'(m.ovf), 32'd0);
        mq.delete();
        mseen = 0;
        @(posedge clk); #2;
        rst_n = 1'b1;
        repeat (6) @(posedge clk);
        #2;
        chk("arst_no_result", 32'(m.out_valid), 32'd0);
        issue(4'd1, 4'd1, 2'b00, 1'b0, 20'd2, 1'b0, 2);
        issue(4'd1, 4'd1, 2'b11, 1'b0, 20'd1, 1'b0, 5);
        drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
